// File: rtl/adc_sched_pkg.sv
// Shared constants for the ADC sample scheduler: FSM encoding, OSR encoding,
// timing defaults and accumulator width.
package adc_sched_pkg;

  localparam int PERIOD_MIN_DEF = 40;
  localparam int TO_LOW_DEF     = 8;
  localparam int TO_HIGH_DEF    = 48;
  localparam int ACC_W          = 15;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_ARM       = 3'd1;
  localparam logic [2:0] S_TRIG      = 3'd2;
  localparam logic [2:0] S_WAIT_LOW  = 3'd3;
  localparam logic [2:0] S_WAIT_HIGH = 3'd4;
  localparam logic [2:0] S_ACCUM     = 3'd5;
  localparam logic [2:0] S_EMIT      = 3'd6;

  localparam logic [1:0] OSR_1 = 2'd0;
  localparam logic [1:0] OSR_2 = 2'd1;
  localparam logic [1:0] OSR_4 = 2'd2;
  localparam logic [1:0] OSR_8 = 2'd3;

  function automatic logic [3:0] osr_samples(input logic [1:0] osr);
    return 4'd1 << osr;
  endfunction

endpackage

// File: rtl/adc_dual_accum.sv
// Two-channel sample accumulator with sample count, latched OSR and
// shift-average outputs; OSR follows the input only while no block is open.
module adc_dual_accum
  import adc_sched_pkg::*;
(
  input  logic        iCLK_32,
  input  logic        iRST,
  input  logic        i_clr,
  input  logic        i_add,
  input  logic        i_cap_osr,
  input  logic [1:0]  i_osr,
  input  logic [11:0] i_data_a,
  input  logic [11:0] i_data_b,
  output logic        o_last,
  output logic [11:0] o_avg_a,
  output logic [11:0] o_avg_b
);

  logic [ACC_W-1:0] r_acc_a;
  logic [ACC_W-1:0] r_acc_b;
  logic [3:0]       r_cnt;
  logic [1:0]       r_osr;
  logic [ACC_W-1:0] w_shift_a;
  logic [ACC_W-1:0] w_shift_b;

  always_ff @(posedge iCLK_32 or posedge iRST) begin
    if (iRST) begin
      r_acc_a <= '0;
      r_acc_b <= '0;
      r_cnt   <= '0;
      r_osr   <= '0;
    end else begin
      if (i_clr) begin
        r_acc_a <= '0;
        r_acc_b <= '0;
        r_cnt   <= '0;
      end else if (i_add) begin
        r_acc_a <= r_acc_a + {{(ACC_W-12){1'b0}}, i_data_a};
        r_acc_b <= r_acc_b + {{(ACC_W-12){1'b0}}, i_data_b};
        r_cnt   <= r_cnt + 4'd1;
      end
      // Count is 4 bits so it never wraps to 0 before EMIT uses r_osr.
      if (i_cap_osr || (r_cnt == 4'd0)) begin
        r_osr <= i_osr;
      end
    end
  end

  assign o_last    = ((r_cnt + 4'd1) == osr_samples(r_osr));
  assign w_shift_a = r_acc_a >> r_osr;
  assign w_shift_b = r_acc_b >> r_osr;
  assign o_avg_a   = w_shift_a[11:0];
  assign o_avg_b   = w_shift_b[11:0];

endmodule

// File: rtl/adc_sample_scheduler.sv
// Periodic ADC trigger scheduler: issues oSYNC, tracks the iCS_n frame with
// timeouts, averages 2^iOSR frames per result and flags overruns/faults.
module adc_sample_scheduler
  import adc_sched_pkg::*;
#(
  parameter int PERIOD_MIN = PERIOD_MIN_DEF,
  parameter int TO_LOW     = TO_LOW_DEF,
  parameter int TO_HIGH    = TO_HIGH_DEF
) (
  input  logic        iCLK_32,
  input  logic        iRST,
  input  logic        iENABLE,
  input  logic [15:0] iPERIOD,
  input  logic [1:0]  iOSR,
  input  logic        iCLR_ERR,
  input  logic        iCS_n,
  input  logic [11:0] iDATA_A,
  input  logic [11:0] iDATA_B,
  output logic        oSYNC,
  output logic [11:0] oAVG_A,
  output logic [11:0] oAVG_B,
  output logic        oVALID,
  output logic        oBUSY,
  output logic        oOVERRUN,
  output logic        oFAULT
);

  logic [2:0]  r_state;
  logic [15:0] r_per_cnt;
  logic [7:0]  r_to_cnt;
  logic        r_cs_q;
  logic        r_abort;
  logic        r_valid;
  logic        r_ovr;
  logic        r_fault;
  logic [11:0] r_avg_a;
  logic [11:0] r_avg_b;

  logic [15:0] w_period;
  logic        w_expire;
  logic        w_cs_rise;
  logic        w_to_low;
  logic        w_to_high;
  logic        w_fault_evt;
  logic        w_ovr_evt;
  logic        w_add;
  logic        w_clr_acc;
  logic        w_last;
  logic [11:0] w_avg_a;
  logic [11:0] w_avg_b;

  assign w_period    = (iPERIOD < 16'(PERIOD_MIN)) ? 16'(PERIOD_MIN) : iPERIOD;
  assign w_expire    = iENABLE && (r_per_cnt == (w_period - 16'd1));
  assign w_cs_rise   = iCS_n && !r_cs_q;
  // Timeout windows count the entry cycle, so the budget starts at the trigger / the fall.
  assign w_to_low    = (r_state == S_WAIT_LOW) && iCS_n && (r_to_cnt == 8'(TO_LOW - 1));
  assign w_to_high   = (r_state == S_WAIT_HIGH) && !w_cs_rise && (r_to_cnt == 8'(TO_HIGH - 1));
  assign w_fault_evt = w_to_low || w_to_high;
  assign w_ovr_evt   = w_expire && (r_state != S_ARM);
  assign w_add       = (r_state == S_ACCUM) && iENABLE && !r_abort;
  assign w_clr_acc   = w_fault_evt || (r_state == S_EMIT) ||
                       ((r_state == S_ACCUM) && !w_add) ||
                       ((r_state == S_ARM) && !iENABLE);

  adc_dual_accum u_acc (
    .iCLK_32   (iCLK_32),
    .iRST      (iRST),
    .i_clr     (w_clr_acc),
    .i_add     (w_add),
    .i_cap_osr (r_state == S_IDLE),
    .i_osr     (iOSR),
    .i_data_a  (iDATA_A),
    .i_data_b  (iDATA_B),
    .o_last    (w_last),
    .o_avg_a   (w_avg_a),
    .o_avg_b   (w_avg_b)
  );

  always_ff @(posedge iCLK_32 or posedge iRST) begin
    if (iRST) begin
      r_per_cnt <= '0;
    end else if (!iENABLE || w_expire) begin
      r_per_cnt <= '0;
    end else begin
      r_per_cnt <= r_per_cnt + 16'd1;
    end
  end

  always_ff @(posedge iCLK_32 or posedge iRST) begin
    if (iRST) begin
      r_state  <= S_IDLE;
      r_to_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE:      if (iENABLE) r_state <= S_ARM;
        S_ARM: begin
          if (!iENABLE)      r_state <= S_IDLE;
          else if (w_expire) r_state <= S_TRIG;
        end
        S_TRIG: begin
          r_to_cnt <= 8'd1;
          r_state  <= S_WAIT_LOW;
        end
        S_WAIT_LOW: begin
          if (!iCS_n) begin
            r_to_cnt <= 8'd1;
            r_state  <= S_WAIT_HIGH;
          end else if (w_to_low) begin
            r_state <= S_ARM;
          end else begin
            r_to_cnt <= r_to_cnt + 8'd1;
          end
        end
        S_WAIT_HIGH: begin
          if (w_cs_rise)      r_state <= S_ACCUM;
          else if (w_to_high) r_state <= S_ARM;
          else                r_to_cnt <= r_to_cnt + 8'd1;
        end
        S_ACCUM: begin
          if (!w_add)      r_state <= S_IDLE;
          else if (w_last) r_state <= S_EMIT;
          else             r_state <= S_ARM;
        end
        S_EMIT:      r_state <= iENABLE ? S_ARM : S_IDLE;
        default:     r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge iCLK_32 or posedge iRST) begin
    if (iRST) begin
      r_cs_q  <= 1'b1;
      r_abort <= 1'b0;
      r_valid <= 1'b0;
      r_ovr   <= 1'b0;
      r_fault <= 1'b0;
      r_avg_a <= '0;
      r_avg_b <= '0;
    end else begin
      r_cs_q  <= iCS_n;
      r_valid <= (r_state == S_EMIT);
      if ((r_state == S_IDLE) || (r_state == S_ARM)) r_abort <= 1'b0;
      else if (!iENABLE)                             r_abort <= 1'b1;
      if (r_state == S_EMIT) begin
        r_avg_a <= w_avg_a;
        r_avg_b <= w_avg_b;
      end
      if (w_ovr_evt)     r_ovr <= 1'b1;
      else if (iCLR_ERR) r_ovr <= 1'b0;
      if (w_fault_evt)   r_fault <= 1'b1;
      else if (iCLR_ERR) r_fault <= 1'b0;
    end
  end

  assign oSYNC    = (r_state == S_TRIG);
  assign oBUSY    = (r_state >= S_TRIG) && (r_state <= S_ACCUM);
  assign oVALID   = r_valid;
  assign oAVG_A   = r_avg_a;
  assign oAVG_B   = r_avg_b;
  assign oOVERRUN = r_ovr;
  assign oFAULT   = r_fault;

endmodule

// File: tb/tb_adc_sample_scheduler.sv
// Directed bench for adc_sample_scheduler with a simple iCS_n frame model.
module tb_adc_sample_scheduler;
  import adc_sched_pkg::*;

  logic        iCLK_32 = 1'b0;
  logic        iRST, iENABLE, iCLR_ERR, iCS_n;
  logic [15:0] iPERIOD;
  logic [1:0]  iOSR;
  logic [11:0] iDATA_A, iDATA_B;
  logic        oSYNC, oVALID, oBUSY, oOVERRUN, oFAULT;
  logic [11:0] oAVG_A, oAVG_B;

  int errors = 0;
  int checks = 0;
  int n_valid = 0;
  logic [11:0] last_a = '0;
  logic [11:0] last_b = '0;
  int m_mode = 0;   // 0: normal frame, 1: never drops iCS_n
  int m_dly  = 2;
  int m_low  = 5;

  adc_sample_scheduler dut (
    .iCLK_32(iCLK_32), .iRST(iRST), .iENABLE(iENABLE), .iPERIOD(iPERIOD),
    .iOSR(iOSR), .iCLR_ERR(iCLR_ERR), .iCS_n(iCS_n), .iDATA_A(iDATA_A),
    .iDATA_B(iDATA_B), .oSYNC(oSYNC), .oAVG_A(oAVG_A), .oAVG_B(oAVG_B),
    .oVALID(oVALID), .oBUSY(oBUSY), .oOVERRUN(oOVERRUN), .oFAULT(oFAULT)
  );

  always #5 iCLK_32 = ~iCLK_32;

  initial begin
    iCS_n = 1'b1;
    forever begin
      @(negedge iCLK_32);
      if (oSYNC === 1'b1 && m_mode != 1) begin
        repeat (m_dly) @(negedge iCLK_32);
        iCS_n = 1'b0;
        repeat (m_low) @(negedge iCLK_32);
        iCS_n = 1'b1;
      end
    end
  end

  initial begin
    forever begin
      @(negedge iCLK_32);
      if (oVALID === 1'b1) begin
        n_valid++;
        last_a = oAVG_A;
        last_b = oAVG_B;
      end
    end
  end

  task automatic wait_sync(input int limit, output int n);
    n = 0;
    do begin
      @(negedge iCLK_32);
      n++;
    end while (oSYNC !== 1'b1 && n < limit);
    if (oSYNC !== 1'b1) n = -1;
  endtask

  task automatic restart(input logic [15:0] per, input logic [1:0] osr, input int mode, input int low);
    iENABLE = 1'b0;
    iRST    = 1'b1;
    repeat (70) @(negedge iCLK_32);
    m_mode  = mode;
    m_low   = low;
    iPERIOD = per;
    iOSR    = osr;
    n_valid = 0;
    iRST    = 1'b0;
    iENABLE = 1'b1;
  endtask

  task automatic test_reset();
    int n;
    iRST = 1'b1; iENABLE = 1'b0; iCLR_ERR = 1'b0; iPERIOD = 16'd10; iOSR = 2'd0;
    iDATA_A = '0; iDATA_B = '0;
    repeat (3) @(negedge iCLK_32);
    checks++; if ({oSYNC, oVALID, oBUSY, oOVERRUN, oFAULT} !== 5'b0) begin errors++; $display("FAIL reset_flags got=%b exp=00000", {oSYNC, oVALID, oBUSY, oOVERRUN, oFAULT}); end
    checks++; if ({oAVG_A, oAVG_B} !== 24'h0) begin errors++; $display("FAIL reset_avg got=%h exp=000000", {oAVG_A, oAVG_B}); end
    checks++; if (dut.r_state !== S_IDLE) begin errors++; $display("FAIL reset_state got=%0d exp=%0d", dut.r_state, S_IDLE); end
    iRST = 1'b0; iENABLE = 1'b1;
    wait_sync(200, n);
    checks++; if (n !== 40) begin errors++; $display("FAIL first_sync_min got=%0d exp=40", n); end
  endtask

  task automatic test_min_period();
    int n;
    wait_sync(200, n);
    checks++; if (n !== 40) begin errors++; $display("FAIL min_period got=%0d exp=40", n); end
    wait_sync(200, n);
    checks++; if (n !== 40) begin errors++; $display("FAIL min_period2 got=%0d exp=40", n); end
    checks++; if (oOVERRUN !== 1'b0) begin errors++; $display("FAIL min_period_ovr got=%b exp=0", oOVERRUN); end
  endtask

  task automatic test_basic();
    int n;
    restart(16'd100, 2'd0, 0, 5);
    iDATA_A = 12'h123; iDATA_B = 12'hABC;
    wait_sync(300, n);
    checks++; if (n !== 100) begin errors++; $display("FAIL basic_first got=%0d exp=100", n); end
    repeat (20) @(negedge iCLK_32);
    checks++; if (n_valid !== 1) begin errors++; $display("FAIL basic_nvalid got=%0d exp=1", n_valid); end
    checks++; if (last_a !== 12'h123) begin errors++; $display("FAIL basic_avg_a got=%h exp=123", last_a); end
    checks++; if (last_b !== 12'hABC) begin errors++; $display("FAIL basic_avg_b got=%h exp=abc", last_b); end
    wait_sync(300, n);
    checks++; if (n !== 80) begin errors++; $display("FAIL basic_period got=%0d exp=80", n); end
    repeat (20) @(negedge iCLK_32);
    checks++; if (n_valid !== 2) begin errors++; $display("FAIL basic_nvalid2 got=%0d exp=2", n_valid); end
    checks++; if (oAVG_A !== 12'h123) begin errors++; $display("FAIL basic_hold got=%h exp=123", oAVG_A); end
  endtask

  task automatic test_osr4();
    int n;
    logic [11:0] va [8];
    logic [11:0] vb [8];
    va = '{12'd4, 12'd5, 12'd6, 12'd8, 12'd8, 12'd8, 12'd8, 12'd8};
    vb = '{12'h10, 12'h20, 12'h30, 12'h40, 12'd8, 12'd8, 12'd8, 12'd8};
    restart(16'd100, 2'd2, 0, 5);
    for (int i = 0; i < 8; i++) begin
      wait_sync(300, n);
      iDATA_A = va[i]; iDATA_B = vb[i];
      repeat (20) @(negedge iCLK_32);
      if (i == 2) begin
        checks++; if (n_valid !== 0) begin errors++; $display("FAIL osr4_early got=%0d exp=0", n_valid); end
      end
      if (i == 3) begin
        checks++; if (n_valid !== 1) begin errors++; $display("FAIL osr4_nvalid got=%0d exp=1", n_valid); end
        checks++; if (last_a !== 12'd5) begin errors++; $display("FAIL osr4_avg_a got=%h exp=005", last_a); end
        checks++; if (last_b !== 12'h28) begin errors++; $display("FAIL osr4_avg_b got=%h exp=028", last_b); end
      end
    end
    checks++; if (n_valid !== 2) begin errors++; $display("FAIL osr4_nvalid2 got=%0d exp=2", n_valid); end
    checks++; if ({last_a, last_b} !== {12'd8, 12'd8}) begin errors++; $display("FAIL osr4_cleared got=%h exp=008008", {last_a, last_b}); end
  endtask

  task automatic test_osr8();
    int n;
    int k;
    restart(16'd50, 2'd3, 0, 5);
    iDATA_A = 12'hFFF; iDATA_B = 12'hFFF;
    for (int i = 0; i < 8; i++) wait_sync(300, n);
    k = 0;
    while (dut.r_state !== S_EMIT && k < 30) begin
      @(negedge iCLK_32);
      k++;
    end
    checks++; if (dut.u_acc.r_acc_a !== 15'h7FF8) begin errors++; $display("FAIL osr8_acc got=%h exp=7ff8", dut.u_acc.r_acc_a); end
    repeat (5) @(negedge iCLK_32);
    checks++; if (n_valid !== 1) begin errors++; $display("FAIL osr8_nvalid got=%0d exp=1", n_valid); end
    checks++; if ({last_a, last_b} !== 24'hFFFFFF) begin errors++; $display("FAIL osr8_avg got=%h exp=ffffff", {last_a, last_b}); end
  endtask

  task automatic test_overrun();
    int n;
    restart(16'd40, 2'd0, 0, 40);
    wait_sync(300, n);
    checks++; if (n !== 40) begin errors++; $display("FAIL ovr_first got=%0d exp=40", n); end
    wait_sync(300, n);
    m_low = 5;
    checks++; if (n !== 80) begin errors++; $display("FAIL ovr_skip got=%0d exp=80", n); end
    checks++; if (oOVERRUN !== 1'b1) begin errors++; $display("FAIL ovr_set got=%b exp=1", oOVERRUN); end
    repeat (5) @(negedge iCLK_32);
    iCLR_ERR = 1'b1;
    @(negedge iCLK_32);
    iCLR_ERR = 1'b0;
    checks++; if (oOVERRUN !== 1'b0) begin errors++; $display("FAIL ovr_clear got=%b exp=0", oOVERRUN); end
    wait_sync(300, n);
    checks++; if (n !== 34) begin errors++; $display("FAIL ovr_resume got=%0d exp=34", n); end
  endtask

  task automatic test_fault_low();
    int n;
    restart(16'd100, 2'd0, 1, 5);
    wait_sync(300, n);
    repeat (7) @(negedge iCLK_32);
    checks++; if (oFAULT !== 1'b0) begin errors++; $display("FAIL flow_early got=%b exp=0", oFAULT); end
    @(negedge iCLK_32);
    checks++; if (oFAULT !== 1'b1) begin errors++; $display("FAIL flow_set got=%b exp=1", oFAULT); end
    wait_sync(300, n);
    checks++; if (n !== 92) begin errors++; $display("FAIL flow_next_sync got=%0d exp=92", n); end
    checks++; if (n_valid !== 0) begin errors++; $display("FAIL flow_novalid got=%0d exp=0", n_valid); end
  endtask

  task automatic test_fault_high();
    int n;
    restart(16'd100, 2'd0, 0, 60);
    wait_sync(300, n);
    repeat (49) @(negedge iCLK_32);
    checks++; if (oFAULT !== 1'b0) begin errors++; $display("FAIL fhigh_early got=%b exp=0", oFAULT); end
    @(negedge iCLK_32);
    checks++; if (oFAULT !== 1'b1) begin errors++; $display("FAIL fhigh_set got=%b exp=1", oFAULT); end
    iCLR_ERR = 1'b1;
    @(negedge iCLK_32);
    iCLR_ERR = 1'b0;
    checks++; if (oFAULT !== 1'b0) begin errors++; $display("FAIL fhigh_clear got=%b exp=0", oFAULT); end
    checks++; if (n_valid !== 0) begin errors++; $display("FAIL fhigh_novalid got=%0d exp=0", n_valid); end
  endtask

  task automatic test_enable_drop();
    int n;
    restart(16'd100, 2'd2, 0, 20);
    iDATA_A = 12'hFFF; iDATA_B = 12'hFFF;
    wait_sync(300, n);
    repeat (30) @(negedge iCLK_32);
    wait_sync(300, n);
    repeat (10) @(negedge iCLK_32);
    checks++; if (dut.r_state !== S_WAIT_HIGH) begin errors++; $display("FAIL drop_in_wait got=%0d exp=%0d", dut.r_state, S_WAIT_HIGH); end
    iENABLE = 1'b0;
    repeat (10) @(negedge iCLK_32);
    checks++; if (oBUSY !== 1'b1) begin errors++; $display("FAIL drop_completes got=%b exp=1", oBUSY); end
    repeat (10) @(negedge iCLK_32);
    checks++; if (dut.r_state !== S_IDLE) begin errors++; $display("FAIL drop_idle got=%0d exp=%0d", dut.r_state, S_IDLE); end
    checks++; if (n_valid !== 0) begin errors++; $display("FAIL drop_novalid got=%0d exp=0", n_valid); end
    iDATA_A = 12'h100; iDATA_B = 12'h100;
    iENABLE = 1'b1;
    wait_sync(300, n);
    checks++; if (n !== 100) begin errors++; $display("FAIL drop_reenable got=%0d exp=100", n); end
    repeat (30) @(negedge iCLK_32);
    for (int i = 0; i < 3; i++) begin
      wait_sync(300, n);
      repeat (30) @(negedge iCLK_32);
    end
    checks++; if (n_valid !== 1) begin errors++; $display("FAIL drop_nvalid got=%0d exp=1", n_valid); end
    checks++; if ({last_a, last_b} !== 24'h100100) begin errors++; $display("FAIL drop_discard got=%h exp=100100", {last_a, last_b}); end
  endtask

  task automatic test_reset_mid();
    int n;
    restart(16'd100, 2'd0, 0, 20);
    iDATA_A = 12'h123; iDATA_B = 12'hABC;
    wait_sync(300, n);
    repeat (30) @(negedge iCLK_32);
    checks++; if (oAVG_A !== 12'h123) begin errors++; $display("FAIL rmid_pre got=%h exp=123", oAVG_A); end
    wait_sync(300, n);
    repeat (10) @(negedge iCLK_32);
    iRST = 1'b1;
    @(negedge iCLK_32);
    checks++; if ({oSYNC, oVALID, oBUSY, oOVERRUN, oFAULT} !== 5'b0) begin errors++; $display("FAIL rmid_flags got=%b exp=00000", {oSYNC, oVALID, oBUSY, oOVERRUN, oFAULT}); end
    checks++; if ({oAVG_A, oAVG_B} !== 24'h0) begin errors++; $display("FAIL rmid_avg got=%h exp=000000", {oAVG_A, oAVG_B}); end
    checks++; if (dut.r_state !== S_IDLE) begin errors++; $display("FAIL rmid_state got=%0d exp=%0d", dut.r_state, S_IDLE); end
    iRST = 1'b0;
  endtask

  initial begin
    test_reset();
    test_min_period();
    test_basic();
    test_osr4();
    test_osr8();
    test_overrun();
    test_fault_low();
    test_fault_high();
    test_enable_drop();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
